// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- three-phase instruction fetch/latch sequencer.
//
// Every instruction takes three clocks (T0, T1, T2). The opcode and operand
// are latched from program memory on the edge leaving T1. T2 is the execute
// strobe for the downstream decoder. The PC advances on the edge leaving T2
// and wraps after PROG_LEN words.
//
// Optional feature: define SINGLE_STEP_EN to add the step input. A rising
// step seen in IDLE while run is low executes exactly one instruction.
//
// Parameters
//   PROG_LEN  number of program words before the PC wraps (1..16)
// Ports
//   clk       system clock; all state changes on its rising edge
//   rst       synchronous, active-high reset
//   run       level request to execute instructions continuously
//   step      single-instruction request (SINGLE_STEP_EN builds only)
//   mem_data  instruction word from program memory: [7:4] opcode, [3:0] operand
//   mem_addr  program memory address; always equal to the PC
//   opcode    latched opcode
//   operand   latched operand
//   T0/T1/T2  registered, one-hot timing states
//   busy      high in any of T0/T1/T2
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no instruction in flight; PC, opcode and operand hold
// S_T0  | first fetch cycle; mem_data addressed by PC
// S_T1  | second fetch cycle; {opcode, operand} load on exit
// S_T2  | execute strobe; PC advances on exit

module fetch_sequencer #(
   parameter int PROG_LEN = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
`ifdef SINGLE_STEP_EN
   input  logic       step,
`endif
   input  logic [7:0] mem_data,
   output logic [3:0] mem_addr,
   output logic [3:0] opcode,
   output logic [3:0] operand,
   output logic       T0,
   output logic       T1,
   output logic       T2,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      S_T0 = 2'd1,
      S_T1 = 2'd2,
      S_T2 = 2'd3
   } state_t;

   localparam logic [3:0] PC_LAST = 4'(PROG_LEN - 1);

   state_t     state_q, state_d;
   logic [3:0] pc_q, pc_d;
   logic [3:0] opcode_q, opcode_d;
   logic [3:0] operand_q, operand_d;
   logic       t0_q, t0_d;
   logic       t1_q, t1_d;
   logic       t2_q, t2_d;
   logic       busy_q, busy_d;

`ifdef SINGLE_STEP_EN
   logic       step_prev_q, step_prev_d;
   logic       step_start;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;

`ifdef SINGLE_STEP_EN
      step_prev_d = step;
      // A new step needs step to have been low on the previous clock,
      // so holding step high never retriggers.
      step_start  = step && !step_prev_q;
`endif

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = S_T0;
            end
`ifdef SINGLE_STEP_EN
            else if (step_start) begin
               state_d = S_T0;
            end
`endif
         end
         S_T0: state_d = S_T1;
         S_T1: begin
            state_d               = S_T2;
            {opcode_d, operand_d} = mem_data;
         end
         S_T2: begin
            state_d = run ? S_T0 : IDLE;
            pc_d    = (pc_q == PC_LAST) ? 4'd0 : pc_q + 4'd1;
         end
         default: state_d = IDLE;
      endcase

      // Strobes are decoded from the next state so they leave flops
      // aligned with state_q.
      t0_d   = (state_d == S_T0);
      t1_d   = (state_d == S_T1);
      t2_d   = (state_d == S_T2);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= 4'd0;
         opcode_q  <= 4'd0;
         operand_q <= 4'd0;
         t0_q      <= 1'b0;
         t1_q      <= 1'b0;
         t2_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
         t0_q      <= t0_d;
         t1_q      <= t1_d;
         t2_q      <= t2_d;
         busy_q    <= busy_d;
      end
   end

`ifdef SINGLE_STEP_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         step_prev_q <= 1'b0;
      end else begin
         step_prev_q <= step_prev_d;
      end
   end
`endif

   assign mem_addr = pc_q;
   assign opcode   = opcode_q;
   assign operand  = operand_q;
   assign T0       = t0_q;
   assign T1       = t1_q;
   assign T2       = t2_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
`ifdef SINGLE_STEP_EN
   logic       step = 1'b0;
`endif
   logic [7:0] mem_data = 8'h3A;

   logic [3:0] addr_a, op_a, opr_a;
   logic       t0_a, t1_a, t2_a, busy_a;
   logic [3:0] addr_b, op_b, opr_b;
   logic       t0_b, t1_b, t2_b, busy_b;

   always #5 clk = ~clk;

   fetch_sequencer #(.PROG_LEN(16)) u_dut (
      .clk(clk), .rst(rst), .run(run),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .mem_data(mem_data), .mem_addr(addr_a), .opcode(op_a), .operand(opr_a),
      .T0(t0_a), .T1(t1_a), .T2(t2_a), .busy(busy_a)
   );

   fetch_sequencer #(.PROG_LEN(5)) u_dut5 (
      .clk(clk), .rst(rst), .run(run),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .mem_data(mem_data), .mem_addr(addr_b), .opcode(op_b), .operand(opr_b),
      .T0(t0_b), .T1(t1_b), .T2(t2_b), .busy(busy_b)
   );

   // t is {T0,T1,T2}
   typedef struct {
      logic       rst;
      logic       run;
      logic [7:0] md;
      logic [2:0] t;
      logic       busy;
      logic [3:0] addr;
      logic [3:0] op;
      logic [3:0] opr;
      string      name;
   } vec_t;

   typedef struct {
      bit         sel;
      logic [2:0] t;
      logic       busy;
      logic [3:0] addr;
      logic [3:0] op;
      logic [3:0] opr;
      string      name;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_miss = 0;

   function automatic vec_t mk(logic r, logic rn, logic [7:0] md, logic [2:0] t,
                               logic [3:0] addr, logic [7:0] ins, string name);
      vec_t v;
      v.rst = r; v.run = rn; v.md = md; v.t = t; v.busy = |t;
      v.addr = addr; v.op = ins[7:4]; v.opr = ins[3:0]; v.name = name;
      return v;
   endfunction

   task automatic check_one();
      exp_t       e;
      logic [2:0] t;
      logic       b;
      logic [3:0] a, o, p;
      if (sb.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL scoreboard_empty: got no expected entry, required one");
         return;
      end
      e = sb.pop_front();
      if (e.sel) begin
         t = {t0_b, t1_b, t2_b}; b = busy_b; a = addr_b; o = op_b; p = opr_b;
      end else begin
         t = {t0_a, t1_a, t2_a}; b = busy_a; a = addr_a; o = op_a; p = opr_a;
      end
      n_vec++;
      if (t !== e.t || b !== e.busy || a !== e.addr || o !== e.op || p !== e.opr) begin
         n_miss++;
         $display("FAIL %s: got T=%b busy=%b addr=%h op=%h opr=%h, required T=%b busy=%b addr=%h op=%h opr=%h",
                  e.name, t, b, a, o, p, e.t, e.busy, e.addr, e.op, e.opr);
      end
   endtask

   // Drive inputs, clock once, then compare the registered result mid-cycle.
   task automatic apply(bit sel, vec_t v);
      exp_t e;
      rst = v.rst; run = v.run; mem_data = v.md;
      @(posedge clk);
      e.sel = sel; e.t = v.t; e.busy = v.busy; e.addr = v.addr;
      e.op = v.op; e.opr = v.opr; e.name = v.name;
      sb.push_back(e);
      @(negedge clk);
      check_one();
   endtask

   initial begin
      // reset, continuous run with 3A everywhere
      tbl.push_back(mk(1, 1, 8'h3A, 3'b000, 4'd0, 8'h00, "reset"));
      tbl.push_back(mk(0, 1, 8'h3A, 3'b100, 4'd0, 8'h00, "run_t0_a0"));
      tbl.push_back(mk(0, 1, 8'h3A, 3'b010, 4'd0, 8'h00, "run_t1_a0"));
      tbl.push_back(mk(0, 1, 8'h3A, 3'b001, 4'd0, 8'h3A, "run_t2_latch"));
      tbl.push_back(mk(0, 1, 8'h3A, 3'b100, 4'd1, 8'h3A, "run_t0_a1"));
      tbl.push_back(mk(0, 1, 8'h3A, 3'b010, 4'd1, 8'h3A, "run_t1_a1"));
      tbl.push_back(mk(0, 1, 8'h3A, 3'b001, 4'd1, 8'h3A, "run_t2_a1"));
      tbl.push_back(mk(0, 0, 8'h3A, 3'b000, 4'd2, 8'h3A, "stop_idle"));
      tbl.push_back(mk(0, 0, 8'h55, 3'b000, 4'd2, 8'h3A, "idle_hold"));
      // run for a single clock still completes one instruction
      tbl.push_back(mk(0, 1, 8'h3A, 3'b100, 4'd2, 8'h3A, "pulse_t0"));
      tbl.push_back(mk(0, 0, 8'h3A, 3'b010, 4'd2, 8'h3A, "pulse_t1"));
      tbl.push_back(mk(0, 0, 8'h3A, 3'b001, 4'd2, 8'h3A, "pulse_t2"));
      tbl.push_back(mk(0, 0, 8'h3A, 3'b000, 4'd3, 8'h3A, "pulse_idle"));
      // back-to-back 10 then F2
      tbl.push_back(mk(0, 1, 8'h10, 3'b100, 4'd3, 8'h3A, "b2b_t0_a"));
      tbl.push_back(mk(0, 1, 8'h10, 3'b010, 4'd3, 8'h3A, "b2b_t1_a"));
      tbl.push_back(mk(0, 1, 8'h10, 3'b001, 4'd3, 8'h10, "b2b_t2_a"));
      tbl.push_back(mk(0, 1, 8'hF2, 3'b100, 4'd4, 8'h10, "b2b_t0_b_nogap"));
      tbl.push_back(mk(0, 1, 8'hF2, 3'b010, 4'd4, 8'h10, "b2b_t1_b"));
      tbl.push_back(mk(0, 0, 8'hF2, 3'b001, 4'd4, 8'hF2, "b2b_t2_b"));
      tbl.push_back(mk(0, 0, 8'h3A, 3'b000, 4'd5, 8'hF2, "b2b_idle"));
      // walk PC up to 7 and reset during T2
      for (int i = 5; i <= 7; i++) begin
         tbl.push_back(mk(0, 1, 8'h3A, 3'b100, 4'(i), (i == 5) ? 8'hF2 : 8'h3A, "walk_t0"));
         tbl.push_back(mk(0, 1, 8'h3A, 3'b010, 4'(i), (i == 5) ? 8'hF2 : 8'h3A, "walk_t1"));
         tbl.push_back(mk(0, 1, 8'h3A, 3'b001, 4'(i), 8'h3A, "walk_t2"));
      end
      tbl.push_back(mk(1, 1, 8'h3A, 3'b000, 4'd0, 8'h00, "rst_in_t2"));
      tbl.push_back(mk(0, 0, 8'h3A, 3'b000, 4'd0, 8'h00, "rst_t2_after"));
      // reset during T1 must also block the opcode load
      tbl.push_back(mk(0, 1, 8'h55, 3'b100, 4'd0, 8'h00, "pre_rst_t0"));
      tbl.push_back(mk(0, 1, 8'h55, 3'b010, 4'd0, 8'h00, "pre_rst_t1"));
      tbl.push_back(mk(1, 1, 8'h55, 3'b000, 4'd0, 8'h00, "rst_in_t1"));
      tbl.push_back(mk(0, 0, 8'h55, 3'b000, 4'd0, 8'h00, "rst_t1_after"));

      @(negedge clk);
      foreach (tbl[i]) apply(1'b0, tbl[i]);

      // PROG_LEN=5 wrap: addresses 0..4 then 0, never 5
      apply(1'b1, mk(1, 1, 8'h3A, 3'b000, 4'd0, 8'h00, "wrap_reset"));
      for (int k = 0; k < 16; k++) begin
         apply(1'b1, mk(0, 1, 8'h3A, 3'b100 >> (k % 3), 4'((k / 3) % 5),
                        (k >= 2) ? 8'h3A : 8'h00, "wrap_seq"));
      end
      apply(1'b1, mk(0, 0, 8'h3A, 3'b010, 4'd0, 8'h3A, "wrap_drain_t1"));
      apply(1'b1, mk(0, 0, 8'h3A, 3'b001, 4'd0, 8'h3A, "wrap_drain_t2"));
      apply(1'b1, mk(0, 0, 8'h3A, 3'b000, 4'd1, 8'h3A, "wrap_drain_idle"));

`ifdef SINGLE_STEP_EN
      apply(1'b0, mk(1, 0, 8'h3A, 3'b000, 4'd0, 8'h00, "step_reset"));
      step = 1'b1;
      for (int k = 0; k < 10; k++) begin
         apply(1'b0, mk(0, 0, 8'h3A, (k < 3) ? (3'b100 >> k) : 3'b000,
                        (k < 3) ? 4'd0 : 4'd1, (k >= 2) ? 8'h3A : 8'h00, "step_held"));
      end
      step = 1'b0;
      apply(1'b0, mk(0, 0, 8'h3A, 3'b000, 4'd1, 8'h3A, "step_low"));
      step = 1'b1;
      apply(1'b0, mk(0, 0, 8'h3A, 3'b100, 4'd1, 8'h3A, "step2_t0"));
      apply(1'b0, mk(0, 0, 8'h3A, 3'b010, 4'd1, 8'h3A, "step2_t1"));
      apply(1'b0, mk(0, 0, 8'h3A, 3'b001, 4'd1, 8'h3A, "step2_t2"));
      apply(1'b0, mk(0, 0, 8'h3A, 3'b000, 4'd2, 8'h3A, "step2_idle"));
      step = 1'b0;
`endif

      if (sb.size() != 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter PROG_LEN, default 16, meaning the number of program words before the PC wraps; legal range 1..16.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port run, input, 1, level request to execute instructions continuously.
REQ-005 The block SHALL have port mem_data, input, 8, instruction word from program memory: [7:4] opcode, [3:0] operand.
REQ-006 The block SHALL have port mem_addr, output, 4, program memory address, equal to the PC.
REQ-007 The block SHALL have port opcode, output, 4, latched opcode for the downstream decoder.
REQ-008 The block SHALL have port operand, output, 4, latched operand.
REQ-009 The block SHALL have ports T0, T1, T2, each output, 1, one-hot timing states; T2 is the execute strobe consumed by the decoder.
REQ-010 The block SHALL have port busy, output, 1, high in any of T0/T1/T2.
REQ-011 When SINGLE_STEP_EN is defined, the block SHALL have port step, input, 1, single-instruction request.

Function
REQ-012 The block SHALL implement states IDLE, S_T0, S_T1, S_T2; T0/T1/T2 are high only in S_T0/S_T1/S_T2 respectively; all three are low in IDLE.
REQ-013 IDLE -> S_T0 when run=1 (sampled on the clock edge); otherwise remain IDLE.
REQ-014 S_T0 -> S_T1 -> S_T2 unconditionally, one clock each.
REQ-015 S_T2 -> S_T0 if run=1, else IDLE; each instruction takes exactly 3 clocks, with no gap between back-to-back instructions.
REQ-016 mem_addr SHALL equal PC at all times; memory is treated as combinational, with mem_data valid during S_T0 and S_T1.
REQ-017 On the edge leaving S_T1, {opcode, operand} SHALL load mem_data; they SHALL hold stable through S_T2 and until the next S_T1 exit.
REQ-018 On the edge leaving S_T2, PC SHALL increment by 1, wrapping from PROG_LEN-1 to 0; no other state changes PC.
REQ-019 Deasserting run mid-instruction SHALL NOT abort it; the current instruction completes through S_T2, then the FSM enters IDLE.
REQ-020 In IDLE, PC, opcode and operand SHALL hold their values; resuming run continues from the held PC.
REQ-021 T0/T1/T2 and busy SHALL be registered state decodes, glitch-free and mutually exclusive.

Reset
REQ-022 On rst=1 at a clock edge, the FSM SHALL enter IDLE and set PC=0, opcode=0, operand=0; T0=T1=T2=busy=0 in the following cycle.
REQ-023 Reset SHALL override every other input, including mid-instruction (S_T1 or S_T2); the interrupted instruction's PC increment SHALL NOT occur.
REQ-024 While rst=1, run (and step, if present) SHALL be ignored.

Configuration
REQ-025 Macro SINGLE_STEP_EN: when defined, a step=1 sample in IDLE with run=0 SHALL execute exactly one instruction (S_T0, S_T1, S_T2) and then return to IDLE, regardless of how long step stays high.
REQ-026 With SINGLE_STEP_EN defined, a further step SHALL require step to return to 0 for at least one clock in IDLE (edge-qualified); run=1 SHALL take priority over step.
REQ-027 Without SINGLE_STEP_EN, the step port and its edge-detect register SHALL be absent, and behaviour SHALL be exactly as in REQ-013..REQ-020.

Verification
REQ-028 Reset then run=1, mem_data=8'h3A for all addresses -> T0,T1,T2 pulse in consecutive cycles; after the first S_T1 exit, opcode=4'h3 and operand=4'hA; mem_addr goes 0,0,0,1,1,1,2...
REQ-029 PROG_LEN=5, run=1 for 16 clocks -> mem_addr sequence 0,1,2,3,4,0 (each held 3 clocks); no value of 5 ever appears.
REQ-030 run=1 for 1 clock only, from IDLE -> exactly one T0/T1/T2 sequence, then IDLE, PC=1, busy=0.
REQ-031 rst pulsed during S_T2 with PC=7 -> next cycle IDLE, PC=0, opcode=0, T2=0; PC never reaches 8.
REQ-032 With SINGLE_STEP_EN defined, step held high for 10 clocks -> exactly one instruction executes (PC 0->1); step low 1 clock then high -> PC 1->2.
REQ-033 Back-to-back program words 8'h10, 8'hF2 -> opcode 1 during the first T2 and opcode F during the second T2; no gap between the T2 of the first instruction and the T0 of the second.
